lfsr13_checker: RTL
===================

// Module: lfsr13_checker
// PURPOSE
//   Receive-side partner of the 13-bit Fibonacci LFSR source (poly taps 12,3,2,0; new LSB = r[12]^r[3]^r[2]^r[0]).
//   Takes the serial bit stream the generator emits, one new LSB per valid beat, and self-synchronises to it.
//   Once synchronised, it checks every following bit and counts mismatches.
//   Used as a link/BIST checker at the far end of any path carrying the generator's serial output.
// PARAMETERS
//   LOCK_MATCHES  16  consecutive correct predictions in TRAIN needed to declare lock (range 1..255)
//   LOSS_ERRORS   4   consecutive mismatches in LOCKED that drop lock (range 1..15)
//   ERR_CNT_W     16  width of saturating error counter
// PORTS
//   clock      in   1          rising-edge clock
//   reset      in   1          reset, asynchronous, active-high
//   din        in   1          received stream bit
//   din_valid  in   1          din is sampled only when 1; state fully frozen when 0
//   clear_cnt  in   1          synchronous clear of err_count (and bit_count when enabled)
//   locked     out  1          1 while in LOCKED
//   err_pulse  out  1          1-cycle pulse, registered, for each mismatch in LOCKED
//   err_count  out  ERR_CNT_W  saturating count of mismatches seen in LOCKED
//   state      out  2          0 = SEED, 1 = TRAIN, 2 = LOCKED
// BEHAVIOUR
//   History register h[12:0]: h[0] is the newest bit. Shift = {h[11:0], bit_in}. Expected bit exp = h[12]^h[3]^h[2]^h[0].
//   Reset: h = 0, fill counter = 0, match counter = 0, err-run counter = 0, state = SEED.
//     Outputs on reset: locked = 0, err_pulse = 0, err_count = 0.
//   Reset mid-operation: immediate return to the reset values; the next bit starts a new SEED.
//   Every action below occurs only on a clock edge with din_valid = 1. err_pulse is 0 on every other cycle.
//   SEED: shift din into h and increment the fill counter. After the 13th bit, go to TRAIN with match counter = 0.
//   TRAIN: compare din with exp, then shift din (the received bit) into h.
//     Match with h != 0: increment match counter. When it reaches LOCK_MATCHES, go to LOCKED with err-run = 0.
//     Mismatch: clear match counter and stay in TRAIN. Self-synchronises 13 bits later.
//     Match with h == 0: clear match counter and stay. An all-zero stream never locks.
//   LOCKED: compare din with exp, then shift exp (the local prediction) into h.
//     This makes the local copy free-running, so a single flipped bit costs exactly 1 error.
//     Mismatch: err_pulse = 1 next cycle; err_count += 1 unless all-ones; err-run += 1.
//       If err-run reaches LOSS_ERRORS, go to SEED: fill counter = 0, locked drops the same edge.
//     Match: err-run = 0.
//   Latency: locked rises on the edge that accepts the LOCK_MATCHES-th match.
//     err_pulse and err_count update on the edge that samples the bad bit.
//   clear_cnt and a counted error on the same edge: err_count = 1 (the error wins over the clear). Otherwise clear -> 0.
//   err_count saturates at 2^ERR_CNT_W-1 and holds until clear_cnt or reset.
//   clear_cnt does not affect state, lock or history.
// CONFIGURATION
//   LFSR13_CHK_BITCNT_EN defined: adds port bit_count out 32. It counts valid bits checked while in LOCKED.
//     It saturates at 2^32-1, is cleared by reset/clear_cnt, and has the same timing as err_count. This supports BER = err_count/bit_count.
//   Not defined: no bit_count port or logic; all other behaviour is identical.
// TESTING
//   Reference model: generator seeded 13'h000F, emitting one new LSB per valid beat.
//   1 Reset, then 29 clean valid bits -> state 0->1 after bit 13; locked = 1 after bit 29; err_count = 0.
//   2 Locked, invert 1 bit -> one err_pulse, err_count = 1, locked stays 1, next 100 clean bits add 0 errors.
//   3 Locked, invert 4 consecutive bits -> err_count = 4, locked = 0 on 4th; 29 more clean bits -> relock.
//   4 Reset, 200 din = 0 -> locked never 1, state stays 1 after bit 13, err_count = 0.
//   5 din_valid toggled 1/0 every cycle with clean stream -> locks after 29 valid beats, not 29 cycles.
//     Then clear_cnt on the same edge as an error -> err_count = 1.
//   6 ERR_CNT_W = 4, locked, 20 isolated errors -> err_count holds 15. Assert reset mid-stream -> all outputs 0 the same cycle.

Source files
------------

// File: rtl/lfsr13_checker.sv
// ---------------------------------------------------------------------------
// lfsr13_checker
//   Receive-side checker for the 13-bit Fibonacci LFSR source
//   (taps 12,3,2,0; new LSB = r[12]^r[3]^r[2]^r[0]).
//
//   The checker first loads 13 received bits into its history register (SEED).
//   It then trains on the received stream until LOCK_MATCHES consecutive
//   predictions are correct (TRAIN). After that it runs its own copy of the
//   LFSR and counts every received bit that disagrees with it (LOCKED).
//   LOSS_ERRORS consecutive mismatches while locked send it back to SEED.
//
//   Optional feature: define LFSR13_CHK_BITCNT_EN to add the bit_count port.
//   bit_count is a saturating count of the valid bits checked while locked.
//   err_count / bit_count gives the bit error rate.
//
// Ports
//   clock      in   1          rising-edge clock
//   reset      in   1          asynchronous, active-high reset
//   din        in   1          received stream bit
//   din_valid  in   1          din is sampled only when 1; state frozen when 0
//   clear_cnt  in   1          synchronous clear of err_count (and bit_count)
//   locked     out  1          1 while in LOCKED
//   err_pulse  out  1          registered 1-cycle pulse per mismatch in LOCKED
//   err_count  out  ERR_CNT_W  saturating count of mismatches seen in LOCKED
//   state      out  2          0 = SEED, 1 = TRAIN, 2 = LOCKED
//   bit_count  out  32         (LFSR13_CHK_BITCNT_EN only) bits checked in LOCKED
// ---------------------------------------------------------------------------
module lfsr13_checker #(
  parameter int LOCK_MATCHES = 16,
  parameter int LOSS_ERRORS  = 4,
  parameter int ERR_CNT_W    = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 din,
  input  logic                 din_valid,
  input  logic                 clear_cnt,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
`ifdef LFSR13_CHK_BITCNT_EN
  output logic [31:0]          bit_count,
`endif
  output logic [1:0]           state
);

  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_TRAIN  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Next bit the generator emits, predicted from its last 13 outputs.
  function automatic logic lfsr_predict(input logic [12:0] hist);
    return hist[12] ^ hist[3] ^ hist[2] ^ hist[0];
  endfunction

  state_t                 state_r;
  logic [12:0]            hist_r;
  logic [3:0]             fill_cnt_r;
  logic [7:0]             match_cnt_r;
  logic [3:0]             err_run_r;
  logic                   locked_r;
  logic                   err_pulse_r;
  logic [ERR_CNT_W-1:0]   err_count_r;

  logic                   exp_s;
  logic                   err_hit_s;
  logic [7:0]             match_inc_s;
  logic [3:0]             err_run_inc_s;
  logic [ERR_CNT_W-1:0]   err_count_nxt_s;

  assign exp_s         = lfsr_predict(hist_r);
  assign match_inc_s   = match_cnt_r + 8'd1;
  assign err_run_inc_s = err_run_r + 4'd1;
  // A counted error is a valid mismatch while locked.
  assign err_hit_s     = din_valid & (state_r == ST_LOCKED) & (din != exp_s);

  // Next error count: an error on the same edge as a clear leaves a count of 1.
  always_comb begin
    err_count_nxt_s = err_count_r;
    if (clear_cnt) begin
      if (err_hit_s) begin
        err_count_nxt_s = ERR_CNT_W'(1);
      end else begin
        err_count_nxt_s = '0;
      end
    end else if (err_hit_s && !(&err_count_r)) begin
      err_count_nxt_s = err_count_r + ERR_CNT_W'(1);
    end else begin
      err_count_nxt_s = err_count_r;
    end
  end

  // Synchronisation state machine, history register and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= ST_SEED;
      hist_r      <= 13'd0;
      fill_cnt_r  <= 4'd0;
      match_cnt_r <= 8'd0;
      err_run_r   <= 4'd0;
      locked_r    <= 1'b0;
      err_pulse_r <= 1'b0;
      err_count_r <= '0;
    end else begin
      err_pulse_r <= err_hit_s;
      err_count_r <= err_count_nxt_s;
      if (din_valid) begin
        case (state_r)
          ST_SEED: begin
            hist_r     <= {hist_r[11:0], din};
            fill_cnt_r <= fill_cnt_r + 4'd1;
            if (fill_cnt_r == 4'd12) begin
              state_r     <= ST_TRAIN;
              match_cnt_r <= 8'd0;
            end
          end
          ST_TRAIN: begin
            // Train on the received bits so a corrupted seed flushes out in 13 beats.
            hist_r <= {hist_r[11:0], din};
            // An all-zero history is the LFSR lock-up state and must never count.
            if ((din == exp_s) && (hist_r != 13'd0)) begin
              match_cnt_r <= match_inc_s;
              if (match_inc_s == 8'(LOCK_MATCHES)) begin
                state_r   <= ST_LOCKED;
                locked_r  <= 1'b1;
                err_run_r <= 4'd0;
              end
            end else begin
              match_cnt_r <= 8'd0;
            end
          end
          ST_LOCKED: begin
            // Free-run on our own prediction so one flipped bit costs one error.
            hist_r <= {hist_r[11:0], exp_s};
            if (din != exp_s) begin
              err_run_r <= err_run_inc_s;
              if (err_run_inc_s == 4'(LOSS_ERRORS)) begin
                state_r    <= ST_SEED;
                locked_r   <= 1'b0;
                fill_cnt_r <= 4'd0;
              end
            end else begin
              err_run_r <= 4'd0;
            end
          end
          default: begin
            state_r    <= ST_SEED;
            locked_r   <= 1'b0;
            fill_cnt_r <= 4'd0;
          end
        endcase
      end
    end
  end

  assign state     = state_r;
  assign locked    = locked_r;
  assign err_pulse = err_pulse_r;
  assign err_count = err_count_r;

`ifdef LFSR13_CHK_BITCNT_EN
  logic [31:0] bit_count_r;
  logic        bit_hit_s;
  logic [31:0] bit_count_nxt_s;

  assign bit_hit_s = din_valid & (state_r == ST_LOCKED);

  // Next checked-bit count, same clear/saturation rules as the error count.
  always_comb begin
    bit_count_nxt_s = bit_count_r;
    if (clear_cnt) begin
      if (bit_hit_s) begin
        bit_count_nxt_s = 32'd1;
      end else begin
        bit_count_nxt_s = 32'd0;
      end
    end else if (bit_hit_s && !(&bit_count_r)) begin
      bit_count_nxt_s = bit_count_r + 32'd1;
    end else begin
      bit_count_nxt_s = bit_count_r;
    end
  end

  // Checked-bit counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_count_r <= 32'd0;
    end else begin
      bit_count_r <= bit_count_nxt_s;
    end
  end

  assign bit_count = bit_count_r;
`endif

endmodule
